seq_serializer: RTL and testbench

- Upstream feeder for the serial sequence-detector stage (Mealy 101/110 detector).
- Accepts parallel words over a valid/ready handshake and buffers one word.
- Shifts each word out one bit per enabled clock on a serial line that drives the detector's serial data input.
- Flags bit validity and the last bit of each word so downstream logic can frame detections.

---
 rtl/seq_serializer_if.sv | 11 +
 rtl/seq_serializer.sv | 93 +++++++++
 tb/tb_seq_serializer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/seq_serializer_if.sv
// rtl/seq_serializer_if.sv - parallel word handshake between a word source and the serializer
interface seq_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;

    modport master (output din, output din_valid, input din_ready);
    modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/seq_serializer.sv
// rtl/seq_serializer.sv - one-word buffered parallel-to-serial feeder for the sequence detector
module seq_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    seq_serializer_if.slave   in_if,
    input  logic              shift_en,
    output logic              Data_out,
    output logic              bit_valid,
    output logic              last_bit,
    output logic              busy
);
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] hold_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_nxt;
    logic [CW-1:0]    cnt;
    logic             hold_full;
    logic             accept;

    function automatic logic out_bit(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    assign in_if.din_ready = rst & ~hold_full;
    assign accept          = in_if.din_valid & in_if.din_ready;
    assign busy            = (state == SHIFT) | hold_full;
    assign shift_nxt       = (MSB_FIRST != 0) ? {shift_q[WIDTH-2:0], 1'b0}
                                              : {1'b0, shift_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            hold_q    <= '0;
            hold_full <= 1'b0;
            shift_q   <= '0;
            cnt       <= '0;
            Data_out  <= 1'b0;
            bit_valid <= 1'b0;
            last_bit  <= 1'b0;
        end else begin
            // accept only ever fires into an empty hold, so it never races the load below
            if (accept) begin
                hold_q    <= in_if.din;
                hold_full <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (hold_full) begin
                        shift_q   <= hold_q;
                        cnt       <= '0;
                        hold_full <= 1'b0;
                        state     <= SHIFT;
                        Data_out  <= out_bit(hold_q);
                        bit_valid <= 1'b1;
                        last_bit  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (shift_en) begin
                        if (cnt == LAST) begin
                            cnt <= '0;
                            if (hold_full) begin
                                shift_q   <= hold_q;
                                hold_full <= 1'b0;
                                Data_out  <= out_bit(hold_q);
                                last_bit  <= 1'b0;
                            end else begin
                                state     <= IDLE;
                                Data_out  <= 1'b0;
                                bit_valid <= 1'b0;
                                last_bit  <= 1'b0;
                            end
                        end else begin
                            shift_q  <= shift_nxt;
                            cnt      <= cnt + 1'b1;
                            Data_out <= out_bit(shift_nxt);
                            last_bit <= ((cnt + 1'b1) == LAST);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_serializer.sv
// tb/tb_seq_serializer.sv - table and scoreboard bench for seq_serializer in both bit orders
module tb_seq_serializer;
    typedef struct packed {
        logic d;
        logic last;
    } exp_t;

    typedef struct {
        logic [7:0] din;
        logic [7:0] stream;
    } vec_t;

    logic clk;
    logic rst;
    logic shift_en_m, shift_en_l;
    logic data_out_m, bit_valid_m, last_bit_m, busy_m;
    logic data_out_l, bit_valid_l, last_bit_l, busy_l;

    int   checks;
    int   errors;
    bit   mon_en;
    bit   det_on;
    int   vcount_m, vcount_l, idle_busy;
    logic [1:0] hist;
    int   det_idx;
    logic [7:0] m101, m110;
    exp_t q_m[$];
    exp_t q_l[$];
    vec_t tbl[5];

    seq_serializer_if #(.WIDTH(8)) if_m ();
    seq_serializer_if #(.WIDTH(8)) if_l ();

    seq_serializer #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .in_if(if_m.slave), .shift_en(shift_en_m),
        .Data_out(data_out_m), .bit_valid(bit_valid_m), .last_bit(last_bit_m), .busy(busy_m)
    );

    seq_serializer #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .in_if(if_l.slave), .shift_en(shift_en_l),
        .Data_out(data_out_l), .bit_valid(bit_valid_l), .last_bit(last_bit_l), .busy(busy_l)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: a bit is consumed at the next edge when bit_valid and shift_en are both high
    always @(negedge clk) begin
        if (mon_en && rst) begin
            if (bit_valid_m && shift_en_m) begin
                if (q_m.size() == 0) begin
                    check("stray_bit_m", 32'(data_out_m), 32'hx);
                end else begin
                    exp_t e;
                    e = q_m.pop_front();
                    check("bit_m", {30'd0, data_out_m, last_bit_m}, {30'd0, e.d, e.last});
                end
                vcount_m++;
                if (det_on) begin
                    if (hist == 2'b10 && data_out_m)  m101[det_idx] = 1'b1;
                    if (hist == 2'b11 && !data_out_m) m110[det_idx] = 1'b1;
                    hist = {hist[0], data_out_m};
                    det_idx++;
                end
            end
            if (busy_m && !bit_valid_m) idle_busy++;
            if (bit_valid_l && shift_en_l) begin
                if (q_l.size() == 0) begin
                    check("stray_bit_l", 32'(data_out_l), 32'hx);
                end else begin
                    exp_t e;
                    e = q_l.pop_front();
                    check("bit_l", {30'd0, data_out_l, last_bit_l}, {30'd0, e.d, e.last});
                end
                vcount_l++;
            end
        end
    end

    task automatic send(input bit lsb, input logic [7:0] w, input logic [7:0] s);
        int n;
        n = 0;
        for (int i = 7; i >= 0; i--) begin
            if (lsb) q_l.push_back(exp_t'{d: s[i], last: (i == 0)});
            else     q_m.push_back(exp_t'{d: s[i], last: (i == 0)});
        end
        if (lsb) begin
            if_l.din = w; if_l.din_valid = 1'b1;
            while (!if_l.din_ready && n < 100) begin @(negedge clk); n++; end
        end else begin
            if_m.din = w; if_m.din_valid = 1'b1;
            while (!if_m.din_ready && n < 100) begin @(negedge clk); n++; end
        end
        if (n >= 100) check("send_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        if_l.din_valid = 1'b0;
        if_m.din_valid = 1'b0;
    endtask

    task automatic drain(input bit lsb);
        int n;
        n = 0;
        if (lsb) begin
            while ((q_l.size() != 0 || busy_l) && n < 300) begin @(negedge clk); n++; end
            check("drain_l_timeout", 32'(n >= 300), 32'd0);
            check("idle_l", {30'd0, bit_valid_l, busy_l}, 32'd0);
        end else begin
            while ((q_m.size() != 0 || busy_m) && n < 300) begin @(negedge clk); n++; end
            check("drain_m_timeout", 32'(n >= 300), 32'd0);
            check("idle_m", {30'd0, bit_valid_m, busy_m}, 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int n;
        checks = 0; errors = 0; mon_en = 0; det_on = 0;
        vcount_m = 0; vcount_l = 0; idle_busy = 0;
        hist = 2'b00; det_idx = 0; m101 = '0; m110 = '0;
        tbl[0] = '{din: 8'hB6, stream: 8'b1011_0110};
        tbl[1] = '{din: 8'h81, stream: 8'b1000_0001};
        tbl[2] = '{din: 8'h6A, stream: 8'b0110_1010};
        tbl[3] = '{din: 8'h00, stream: 8'b0000_0000};
        tbl[4] = '{din: 8'hFF, stream: 8'b1111_1111};

        rst = 1'b0;
        shift_en_m = 1'b1; shift_en_l = 1'b1;
        if_m.din = '0; if_m.din_valid = 1'b0;
        if_l.din = '0; if_l.din_valid = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_outs_m", {28'd0, data_out_m, bit_valid_m, busy_m, if_m.din_ready}, 32'd0);
        check("rst_outs_l", {28'd0, data_out_l, bit_valid_l, busy_l, if_l.din_ready}, 32'd0);
        check("rst_last", {30'd0, last_bit_m, last_bit_l}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {30'd0, if_m.din_ready, if_l.din_ready}, 32'd3);
        mon_en = 1;

        for (int v = 0; v < 5; v++) begin
            vcount_m = 0;
            send(0, tbl[v].din, tbl[v].stream);
            drain(0);
            check("word_bits", 32'(vcount_m), 32'd8);
        end

        // back-to-back pair: exactly one idle-but-busy cycle before the first bit, none between words
        vcount_m = 0; idle_busy = 0;
        send(0, 8'hA5, 8'b1010_0101);
        send(0, 8'h3C, 8'b0011_1100);
        check("b2b_ready_low", 32'(if_m.din_ready), 32'd0);
        n = 0;
        while (!last_bit_m && n < 50) begin @(negedge clk); n++; end
        check("b2b_last_seen", 32'(last_bit_m), 32'd1);
        check("b2b_ready_at_last", 32'(if_m.din_ready), 32'd0);
        @(negedge clk);
        check("b2b_ready_after", 32'(if_m.din_ready), 32'd1);
        drain(0);
        check("b2b_bits", 32'(vcount_m), 32'd16);
        check("b2b_gap", 32'(idle_busy), 32'd1);

        vcount_m = 0;
        send(0, 8'hF0, 8'b1111_0000);
        n = 0;
        do begin @(negedge clk); n++; end while (!bit_valid_m && n < 50);
        @(posedge clk);
        @(posedge clk);
        #1 shift_en_m = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_hold", {29'd0, data_out_m, bit_valid_m, last_bit_m}, 32'b110);
        end
        @(posedge clk);
        #1 shift_en_m = 1'b1;
        drain(0);
        check("stall_bits", 32'(vcount_m), 32'd8);

        vcount_l = 0;
        send(1, 8'h01, 8'b1000_0000);
        drain(1);
        check("lsb_bits", 32'(vcount_l), 32'd8);

        send(0, 8'hFF, 8'b1111_1111);
        send(0, 8'h55, 8'b0101_0101);
        @(posedge clk);
        @(posedge clk);
        #3;
        check("pre_rst_active", {30'd0, data_out_m, busy_m}, 32'd3);
        mon_en = 0;
        rst = 1'b0;
        #1;
        check("async_rst_outs", {27'd0, data_out_m, bit_valid_m, last_bit_m, busy_m, if_m.din_ready}, 32'd0);
        q_m.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (bit_valid_m || busy_m) n++;
        end
        check("no_residual", 32'(n), 32'd0);
        mon_en = 1;

        hist = 2'b00; det_idx = 0; m101 = '0; m110 = '0; det_on = 1;
        send(0, 8'hB0, 8'b1011_0000);
        drain(0);
        det_on = 0;
        check("det_101_pos", 32'(m101), 32'h04);
        check("det_110_pos", 32'(m110), 32'h10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
